logic_unit_seq: RTL
===================

Name: logic_unit_seq

Overview:
- Parametrised, multi-cycle bitwise logic unit; successor to the fixed 32-bit OR gate array in the MIPS ALU.
- Supports AND/OR/XOR/NOR at any WIDTH, processed SLICE bits per cycle to trade area for latency.
- Valid/ready handshake on input and output, so the ALU/execute stage can stall on it.
- Sits beside the adder in the ALU datapath; its result feeds the ALU result mux.

Parameters:
- WIDTH, 32, operand/result width in bits.
- SLICE, 8, bits processed per cycle; WIDTH % SLICE == 0 required, and SLICE == WIDTH is legal.
- NSLICE, WIDTH/SLICE, derived localparam: number of RUN cycles.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands/op presented.
- in_ready  out  1  unit can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  2  00=AND, 01=OR, 10=XOR, 11=NOR.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- result  out  WIDTH  bitwise result.
- zero  out  1  present only with ZERO_FLAG_EN; result == 0.

Behaviour:
- Clocking: single clock clk; reset is synchronous and active-high; all state updates occur on the rising edge of clk.
- Reset values: state=IDLE, in_ready=1, out_valid=0, result=0, slice counter=0, captured a/b/op=0, zero=1 (if built).
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - When in_valid=1 at an edge: capture a, b and op; clear result; set counter to 0; go to RUN.
- RUN:
  - in_ready=0, out_valid=0.
  - Each cycle: result[cnt*SLICE +: SLICE] <= op applied to the captured a/b slice; cnt++.
  - When cnt==NSLICE-1: write the final slice and go to DONE.
- DONE:
  - out_valid=1; result is stable.
  - When out_ready=1 at an edge: go to IDLE.
  - No new accept occurs in the same cycle, so throughput is one operation per NSLICE+2 cycles.
- Latency: handshake accepted at edge of cycle N -> out_valid=1 in cycle N+NSLICE+1 (defaults: N+5).
- Input holding: inputs are sampled only on the accept edge; later changes to a/b/op are ignored.
- in_valid while not in IDLE: ignored, because in_ready=0; upstream must hold.
- out_ready while not in DONE: ignored.
- Result visibility: result is valid only while out_valid=1. During RUN, upper bits not yet computed read 0.
- Reset has priority over all other events. Reset mid-RUN or in DONE aborts the operation: IDLE next cycle, out_valid=0, result=0, and no result is emitted.
- Arithmetic: purely bitwise, no carries. NOR = ~(a|b) per bit.
- Counter width: $clog2(NSLICE), minimum 1 bit. Wrap-around is impossible because of the NSLICE-1 terminal compare.

Optional Feature:
- LOGIC_UNIT_ZERO_FLAG_EN defined:
  - Adds the registered output zero.
  - zero is updated when entering DONE (== (final result == 0)) and held through DONE.
  - zero resets to 1 and is cleared/recomputed per operation.
- Undefined: no zero port and no extra logic. The ALU derives the zero flag elsewhere.

Decomposition:
- Package logic_unit_pkg:
  - 2-bit op typedef/enum LU_AND/LU_OR/LU_XOR/LU_NOR.
  - FSM state enum.
- Sub-module logic_slice: combinational SLICE-bit op unit with ports (a_s, b_s, op, y_s). Instantiated once and time-multiplexed by the counter.

Test Plan:
- OR (defaults): a=F0F00000, b=0F0F00FF, op=01 accepted at cycle 0 -> out_valid at cycle 5, result=FFFF00FF, in_ready=0 in cycles 1-5.
- AND/XOR/NOR: a=FFFF0000, b=0F0F0F0F -> AND=0F0F0000, XOR=F0F00F0F, NOR=0000F0F0. Run back-to-back, each with out_ready=1.
- Backpressure: out_ready=0 for 3 cycles in DONE -> out_valid and result held constant; in_valid=1 meanwhile is not accepted; IDLE one cycle after out_ready=1.
- Reset mid-RUN: reset=1 at cycle 2 after accept -> next cycle state IDLE, result=0, out_valid=0, in_ready=1; no spurious out_valid afterwards.
- Parameter sweep (WIDTH=16, SLICE=16): XOR a=AAAA, b=FFFF -> 5555 with out_valid 2 cycles after accept. Also run WIDTH=64, SLICE=4 with random vectors checked against a golden model.
- With LOGIC_UNIT_ZERO_FLAG_EN: AND a=AAAAAAAA, b=55555555 -> result=0, zero=1. OR of the same operands -> zero=0.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared types for the sliced logic unit.
// Operation codes and FSM state encoding.
package logic_unit_pkg;

    typedef enum logic [1:0] {
        LU_AND = 2'b00,
        LU_OR  = 2'b01,
        LU_XOR = 2'b10,
        LU_NOR = 2'b11
    } lu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } lu_state_e;

endpackage

// File: rtl/logic_unit_seq_slice.sv
// Combinational SLICE-bit logic op, shared by every slice position.
// The parent time-multiplexes it with its slice counter.
module logic_slice
    import logic_unit_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a_s,
    input  logic [SLICE-1:0] b_s,
    input  logic [1:0]       op,
    output logic [SLICE-1:0] y_s
);

    // Apply the selected bitwise op to one slice
    always_comb begin
        y_s = '0;
        unique case (op)
            LU_AND: y_s = a_s & b_s;
            LU_OR:  y_s = a_s | b_s;
            LU_XOR: y_s = a_s ^ b_s;
            LU_NOR: y_s = ~(a_s | b_s);
            default: y_s = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_seq.sv
// Multi-cycle bitwise logic unit, SLICE bits per cycle, valid/ready I/O.
// Define LOGIC_UNIT_ZERO_FLAG_EN to add the registered zero output.
module logic_unit_seq
    import logic_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
   ,output logic             zero
`endif
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    lu_state_e        state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] res_n;
    logic [SLICE-1:0] a_s;
    logic [SLICE-1:0] b_s;
    logic [SLICE-1:0] y_s;

    assign a_s = a_q[cnt_q*SLICE +: SLICE];
    assign b_s = b_q[cnt_q*SLICE +: SLICE];

    logic_slice #(.SLICE(SLICE)) u_slice (
        .a_s (a_s),
        .b_s (b_s),
        .op  (op_q),
        .y_s (y_s)
    );

    // Current result with this cycle's slice merged in
    always_comb begin
        res_n = result_q;
        res_n[cnt_q*SLICE +: SLICE] = y_s;
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;

    // Accept / slice-by-slice compute / hold-until-taken sequencer
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        a_q      <= a;
                        b_q      <= b;
                        op_q     <= op;
                        result_q <= '0;
                        cnt_q    <= '0;
                        state_q  <= S_RUN;
                    end
                end
                S_RUN: begin
                    result_q <= res_n;
                    if (cnt_q == LAST) begin
                        cnt_q   <= '0;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    // Zero flag latched from the final result on entry to DONE
    always_ff @(posedge clk) begin
        if (reset) begin
            zero <= 1'b1;
        end else if (state_q == S_IDLE && in_valid) begin
            zero <= 1'b0;
        end else if (state_q == S_RUN && cnt_q == LAST) begin
            zero <= (res_n == '0);
        end
    end
`endif

endmodule
